dx_stage_register: RTL and testbench

//   Decode/Execute pipeline register with hazard control. Latches F/D instruction, PC and regfile

---
 rtl/mips_isa_pkg.sv | 57 +++++
 rtl/load_use_detector.sv | 31 +++
 rtl/dx_stage_register.sv | 124 ++++++++++++
 tb/tb_dx_stage_register.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the D/X stage: opcode/aluop encodings, field extractors,
// the bubble word and the mul/div sequencing state type.
package mips_isa_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  localparam logic [4:0] OP_RTYPE  = 5'b00000;
  localparam logic [4:0] OP_LW     = 5'b01000;
  localparam logic [4:0] OP_SW     = 5'b00111;
  localparam logic [4:0] OP_BNE    = 5'b00010;
  localparam logic [4:0] OP_BLT    = 5'b00110;
  localparam logic [4:0] OP_JR     = 5'b00100;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic {
    DX_IDLE = 1'b0,
    DX_BUSY = 1'b1
  } dx_state_e;

  function automatic logic [4:0] f_op(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] instr);
    return instr[ALUOP_HI:ALUOP_LO];
  endfunction

  function automatic logic is_multdiv(input logic [31:0] instr);
    return (f_op(instr) == OP_RTYPE) &&
           ((f_aluop(instr) == ALUOP_MUL) || (f_aluop(instr) == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational lw load-use hazard check between the instruction in X and the one in F/D.
module load_use_detector
  import mips_isa_pkg::*;
(
  input  logic [31:0] x_instruction,
  input  logic [31:0] fd_instruction,
  output logic        hazard
);

  logic [4:0] x_rd;
  logic [4:0] fd_op;
  logic       x_is_lw;
  logic       fd_reads_rd;
  logic       unused_bits;

  assign x_rd    = f_rd(x_instruction);
  assign fd_op   = f_op(fd_instruction);
  assign x_is_lw = (f_op(x_instruction) == OP_LW) && (x_rd != 5'd0);

  // Stores, compare-branches and jr read their rd field as a source operand.
  assign fd_reads_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                       (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign hazard = x_is_lw &&
                  ((x_rd == f_rs(fd_instruction)) ||
                   (x_rd == f_rt(fd_instruction)) ||
                   (fd_reads_rd && (x_rd == f_rd(fd_instruction))));

  assign unused_bits = ^{x_instruction[21:0], fd_instruction[11:0]};

endmodule

// File: rtl/dx_stage_register.sv
// Decode/Execute pipeline register with load-use bubble, mul/div hold and flush squash.
// Optional stall cycle counter port enabled by defining DX_PERF_COUNT_EN.
module dx_stage_register
  import mips_isa_pkg::*;
#(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = NOP_WORD
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     fd_instruction,
  input  logic [XLEN-1:0] fd_pc,
  input  logic [XLEN-1:0] fd_reg_a,
  input  logic [XLEN-1:0] fd_reg_b,
  input  logic            flush,
  input  logic            multdiv_ready,
  output logic [31:0]     execute_instruction,
  output logic [XLEN-1:0] execute_pc,
  output logic [XLEN-1:0] execute_a,
  output logic [XLEN-1:0] execute_b,
  output logic            stall_fd,
  output logic            execute_hold,
  output logic            multdiv_start,
  output logic            multdiv_is_div,
  output dx_state_e       debug_state
`ifdef DX_PERF_COUNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  dx_state_e       state_q, state_d;

  logic load_use;
  logic md_start;
  logic md_wait;

  load_use_detector u_load_use_detector (
    .x_instruction  (ir_q),
    .fd_instruction (fd_instruction),
    .hazard         (load_use)
  );

  // The start cycle also holds X: the mul/div must stay put until its ready pulse.
  assign md_start = !flush && (state_q == DX_IDLE) && is_multdiv(ir_q);
  assign md_wait  = !flush && (state_q == DX_BUSY) && !multdiv_ready;

  assign execute_hold   = md_start || md_wait;
  assign stall_fd       = execute_hold || (!flush && load_use);
  assign multdiv_start  = md_start;
  assign multdiv_is_div = md_start && (f_aluop(ir_q) == ALUOP_DIV);

  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    state_d = state_q;
    if (flush) begin
      ir_d    = NOP;
      pc_d    = '0;
      a_d     = '0;
      b_d     = '0;
      state_d = DX_IDLE;
    end else if (execute_hold) begin
      state_d = DX_BUSY;
    end else if (load_use) begin
      ir_d    = NOP;
      pc_d    = '0;
      a_d     = '0;
      b_d     = '0;
      state_d = DX_IDLE;
    end else begin
      ir_d    = fd_instruction;
      pc_d    = fd_pc;
      a_d     = fd_reg_a;
      b_d     = fd_reg_b;
      state_d = DX_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ir_q    <= NOP;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      state_q <= DX_IDLE;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      state_q <= state_d;
    end
  end

  assign execute_instruction = ir_q;
  assign execute_pc          = pc_q;
  assign execute_a           = a_q;
  assign execute_b           = b_q;
  assign debug_state         = state_q;

`ifdef DX_PERF_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {31'd0, stall_fd};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dx_stage_register.sv
// Directed bench for dx_stage_register: reset, load-use bubbles, mul/div hold, flush, reset mid-op.
// Define DX_PERF_COUNT_EN to also exercise the stall cycle counter.
module tb_dx_stage_register;
  import mips_isa_pkg::*;

  localparam int XLEN = 32;

  logic            clock;
  logic            reset_n;
  logic [31:0]     fd_instruction;
  logic [XLEN-1:0] fd_pc;
  logic [XLEN-1:0] fd_reg_a;
  logic [XLEN-1:0] fd_reg_b;
  logic            flush;
  logic            multdiv_ready;
  logic [31:0]     execute_instruction;
  logic [XLEN-1:0] execute_pc;
  logic [XLEN-1:0] execute_a;
  logic [XLEN-1:0] execute_b;
  logic            stall_fd;
  logic            execute_hold;
  logic            multdiv_start;
  logic            multdiv_is_div;
  dx_state_e       debug_state;
`ifdef DX_PERF_COUNT_EN
  logic [31:0]     stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  dx_stage_register #(.XLEN(XLEN), .NOP(32'h0)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .fd_instruction      (fd_instruction),
    .fd_pc               (fd_pc),
    .fd_reg_a            (fd_reg_a),
    .fd_reg_b            (fd_reg_b),
    .flush               (flush),
    .multdiv_ready       (multdiv_ready),
    .execute_instruction (execute_instruction),
    .execute_pc          (execute_pc),
    .execute_a           (execute_a),
    .execute_b           (execute_b),
    .stall_fd            (stall_fd),
    .execute_hold        (execute_hold),
    .multdiv_start       (multdiv_start),
    .multdiv_is_div      (multdiv_is_div),
    .debug_state         (debug_state)
`ifdef DX_PERF_COUNT_EN
    ,
    .stall_cycles        (stall_cycles)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic drive_fd(input logic [31:0] instr, input logic [31:0] pc);
    fd_instruction = instr;
    fd_pc          = pc;
    fd_reg_a       = 32'hA000_0000 | pc;
    fd_reg_b       = 32'hB000_0000 | pc;
  endtask

  task automatic scoreboard_pop(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, execute_instruction, exp);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    flush         = 1'b0;
    multdiv_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One load-use bubble: lw r5 then add r6,r5,r2.
  task automatic load_use_once();
    drive_fd(itype(OP_LW, 5'd5, 5'd1, 17'd0), 32'd40);
    tick();
    drive_fd(rtype(5'd6, 5'd5, 5'd2, 5'd0), 32'd41);
    tick();
    tick();
  endtask

  logic [31:0] lw_r5, add_r5, lw_r0, add_r0, sw_r5, addi_r5, mul_i, div_i, add_n;
  int stall_n, hold_n, start_n;
  logic ir_held;

  initial begin
    lw_r5   = itype(OP_LW, 5'd5, 5'd1, 17'd4);
    add_r5  = rtype(5'd6, 5'd5, 5'd2, 5'd0);
    lw_r0   = itype(OP_LW, 5'd0, 5'd1, 17'd4);
    add_r0  = rtype(5'd6, 5'd0, 5'd2, 5'd0);
    sw_r5   = itype(OP_SW, 5'd5, 5'd1, 17'd0);
    addi_r5 = itype(5'b00101, 5'd5, 5'd1, 17'd0);
    mul_i   = rtype(5'd3, 5'd1, 5'd2, ALUOP_MUL);
    div_i   = rtype(5'd3, 5'd1, 5'd2, ALUOP_DIV);
    add_n   = rtype(5'd7, 5'd1, 5'd2, 5'd0);

    drive_fd(lw_r5, 32'd9);
    do_reset();
    check("rst_ir",    execute_instruction, 32'd0);
    check("rst_pc",    execute_pc,          32'd0);
    check("rst_a",     execute_a,           32'd0);
    check("rst_b",     execute_b,           32'd0);
    check("rst_state", 32'(debug_state),    32'(DX_IDLE));

    // load-use: lw r5 then add r6,r5,r2 -> one bubble
    drive_fd(lw_r5, 32'd10);
    exp_q.push_back(lw_r5);
    exp_q.push_back(32'd0);
    exp_q.push_back(add_r5);
    tick();
    scoreboard_pop("lu_ir_lw");
    check("lu_pc_lw", execute_pc, 32'd10);
    check("lu_a_lw",  execute_a,  32'hA000_000A);
    check("lu_b_lw",  execute_b,  32'hB000_000A);
    drive_fd(add_r5, 32'd11);
    settle();
    check("lu_stall", 32'(stall_fd), 32'd1);
    check("lu_nostart", 32'(multdiv_start), 32'd0);
    tick();
    scoreboard_pop("lu_ir_bubble");
    check("lu_pc_bubble", execute_pc, 32'd0);
    settle();
    check("lu_stall_clear", 32'(stall_fd), 32'd0);
    tick();
    scoreboard_pop("lu_ir_add");
    check("lu_pc_add", execute_pc, 32'd11);

    // r0 destination never hazards
    drive_fd(lw_r0, 32'd12);
    tick();
    drive_fd(add_r0, 32'd13);
    settle();
    check("r0_nostall", 32'(stall_fd), 32'd0);
    tick();
    check("r0_ir_add", execute_instruction, add_r0);

    // sw reads rd; an ordinary I-type with the same rd does not
    drive_fd(lw_r5, 32'd14);
    tick();
    drive_fd(sw_r5, 32'd15);
    settle();
    check("sw_stall", 32'(stall_fd), 32'd1);
    tick();
    tick();
    check("sw_ir", execute_instruction, sw_r5);
    drive_fd(lw_r5, 32'd16);
    tick();
    drive_fd(addi_r5, 32'd17);
    settle();
    check("addi_nostall", 32'(stall_fd), 32'd0);
    tick();

    // mul with ready 32 cycles after the start cycle
    drive_fd(mul_i, 32'd20);
    tick();
    drive_fd(add_n, 32'd21);
    stall_n = 0;
    hold_n  = 0;
    start_n = 0;
    ir_held = 1'b1;
    for (int c = 0; c < 40; c++) begin
      multdiv_ready = (c == 32);
      settle();
      if (stall_fd) stall_n++;
      if (execute_hold) hold_n++;
      if (multdiv_start) start_n++;
      if (c == 0) check("mul_is_div", 32'(multdiv_is_div), 32'd0);
      if (c <= 32 && execute_instruction !== mul_i) ir_held = 1'b0;
      tick();
    end
    multdiv_ready = 1'b0;
    check("mul_start_n", 32'(start_n), 32'd1);
    check("mul_stall_n", 32'(stall_n), 32'd32);
    check("mul_hold_n",  32'(hold_n),  32'd32);
    check("mul_ir_held", 32'(ir_held), 32'd1);
    check("mul_next_ir", execute_instruction, add_n);
    check("mul_next_pc", execute_pc, 32'd21);
    check("mul_idle",    32'(debug_state), 32'(DX_IDLE));

    // back-to-back mul then div
    drive_fd(mul_i, 32'd22);
    tick();
    drive_fd(div_i, 32'd23);
    tick();
    multdiv_ready = 1'b1;
    settle();
    check("b2b_ready_nostall", 32'(stall_fd), 32'd0);
    tick();
    multdiv_ready = 1'b0;
    drive_fd(add_n, 32'd24);
    settle();
    check("b2b_div_ir",    execute_instruction, div_i);
    check("b2b_div_start", 32'(multdiv_start), 32'd1);
    check("b2b_div_isdiv", 32'(multdiv_is_div), 32'd1);
    check("b2b_div_state", 32'(debug_state), 32'(DX_IDLE));
    tick();
    check("b2b_div_busy", 32'(debug_state), 32'(DX_BUSY));

    // reset in the middle of BUSY, then a stray ready pulse
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive_fd(32'd0, 32'd0);
    settle();
    check("mid_rst_ir",    execute_instruction, 32'd0);
    check("mid_rst_state", 32'(debug_state), 32'(DX_IDLE));
    check("mid_rst_stall", 32'(stall_fd), 32'd0);
    check("mid_rst_hold",  32'(execute_hold), 32'd0);
    check("mid_rst_start", 32'(multdiv_start), 32'd0);
    multdiv_ready = 1'b1;
    settle();
    check("stray_ready_hold", 32'(execute_hold), 32'd0);
    tick();
    multdiv_ready = 1'b0;
    check("stray_ready_state", 32'(debug_state), 32'(DX_IDLE));

    // flush coinciding with a load-use hazard
    drive_fd(lw_r5, 32'd30);
    tick();
    drive_fd(add_r5, 32'd31);
    flush = 1'b1;
    settle();
    check("flush_stall", 32'(stall_fd), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check("flush_ir",    execute_instruction, 32'd0);
    check("flush_pc",    execute_pc, 32'd0);
    check("flush_state", 32'(debug_state), 32'(DX_IDLE));
    check("flush_after_nostall", 32'(stall_fd), 32'd0);

    // flush while a mul is busy
    drive_fd(mul_i, 32'd32);
    tick();
    drive_fd(add_n, 32'd33);
    tick();
    flush = 1'b1;
    settle();
    check("flush_busy_nohold", 32'(execute_hold), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check("flush_busy_state", 32'(debug_state), 32'(DX_IDLE));
    check("flush_busy_start", 32'(multdiv_start), 32'd0);
    check("flush_busy_ir",    execute_instruction, 32'd0);

`ifdef DX_PERF_COUNT_EN
    drive_fd(32'd0, 32'd0);
    do_reset();
    check("cnt_rst", stall_cycles, 32'd0);
    for (int k = 0; k < 3; k++) load_use_once();
    drive_fd(div_i, 32'd50);
    tick();
    drive_fd(add_n, 32'd51);
    for (int c = 0; c < 12; c++) begin
      multdiv_ready = (c == 10);
      tick();
    end
    multdiv_ready = 1'b0;
    check("cnt_total", stall_cycles, 32'd13);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
